// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding,
// parameter defaults and the fetched-entry record.
package fetch_sequencer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_INC   = 32'd4;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry valid/ready buffer: a registered output stage plus one skid entry
// that absorbs a returning fetch while decode is stalled.
module fetch_skid_buffer
  import fetch_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  fetch_entry_t in_data,
  output logic         in_ready,
  output logic         space_next,
  output logic         out_valid,
  output fetch_entry_t out_data,
  input  logic         out_ready
);

  logic         skid_valid;
  fetch_entry_t skid_data;
  logic         push;
  logic         out_free;
  logic         out_valid_nxt;
  fetch_entry_t out_data_nxt;
  logic         skid_valid_nxt;
  fetch_entry_t skid_data_nxt;

  assign in_ready = !skid_valid;
  assign push     = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  always_comb begin
    out_valid_nxt  = out_valid;
    out_data_nxt   = out_data;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;
    if (flush) begin
      out_valid_nxt  = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid_nxt  = 1'b1;
        out_data_nxt   = skid_data;
        skid_valid_nxt = push;
        skid_data_nxt  = push ? in_data : skid_data;
      end else if (push) begin
        out_valid_nxt = 1'b1;
        out_data_nxt  = in_data;
      end else begin
        out_valid_nxt = 1'b0;
      end
    end else if (push) begin
      skid_valid_nxt = 1'b1;
      skid_data_nxt  = in_data;
    end
  end

  // The sequencer only issues when the skid will be empty after this edge.
  assign space_next = !skid_valid_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
    end else begin
      out_valid  <= out_valid_nxt;
      out_data   <= out_data_nxt;
      skid_valid <= skid_valid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    skid_data <= skid_data_nxt;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding memory request, redirect with
// drain of an in-flight request, and a two-entry buffer towards decode.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] PC_INC   = DEF_PC_INC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc
);

  logic [1:0]   state;
  logic         accept;
  logic         in_ready;
  logic         space_next;
  logic [31:0]  pc_step;
  fetch_entry_t fetched;
  fetch_entry_t out_entry;

  assign pc_step = pc + PC_INC;
  assign accept  = (state == ST_FETCH) && imem_req && imem_ack && !redirect;
  assign fetched = '{word: imem_rdata, addr: imem_addr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_FETCH;
          if (redirect) pc <= align_pc(redirect_pc);
        end
        ST_FETCH: begin
          if (redirect) begin
            pc <= align_pc(redirect_pc);
            // An un-acked request must complete before the bus is reused.
            if (imem_req && !imem_ack) state <= ST_DRAIN;
            else imem_req <= 1'b0;
          end else if (imem_req) begin
            if (imem_ack) begin
              pc        <= pc_step;
              imem_req  <= space_next;
              imem_addr <= pc_step;
            end
          end else if (space_next) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        ST_DRAIN: begin
          if (redirect) pc <= align_pc(redirect_pc);
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= ST_FETCH;
          end
        end
        default: begin
          state    <= ST_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect),
    .in_valid   (accept),
    .in_data    (fetched),
    .in_ready   (in_ready),
    .space_next (space_next),
    .out_valid  (instr_valid),
    .out_data   (out_entry),
    .out_ready  (!stall)
  );

  assign instr    = out_entry.word;
  assign instr_pc = out_entry.addr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic,
// checked against a transaction-level model of the fetch stream.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] INC    = 32'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc;

  int total = 0;
  int bad = 0;
  int consumed = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;

  exp_t        q[$];
  logic [31:0] next_issue;
  logic        draining;
  logic        prev_out;
  logic [31:0] prev_addr;

  fetch_sequencer #(.RESET_PC(RST_PC), .PC_INC(INC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    next_issue = RST_PC;
    draining   = 1'b0;
    prev_out   = 1'b0;
    prev_addr  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    imem_ack = 1'b0;
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_pc", pc, RST_PC);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_model();
    check("valid", {31'd0, instr_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      check("instr_pc", instr_pc, q[0].addr);
      check("instr", instr, q[0].word);
    end
    check("pc", pc, next_issue);
    if (prev_out) begin
      check("hold_req", {31'd0, imem_req}, 32'd1);
      check("hold_addr", imem_addr, prev_addr);
    end else if (imem_req) begin
      check("issue_addr", imem_addr, next_issue);
    end
    if (q.size() == 2) check("full_no_req", {31'd0, imem_req}, 32'd0);
  endtask

  // ackmode: 0 = no ack, 1 = ack whenever a request is up, 2 = ack regardless
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input int ackmode);
    logic ack;
    @(negedge clk);
    check_model();
    ack = (ackmode == 2) || (ackmode == 1 && imem_req);
    stall = st;
    redirect = rd;
    redirect_pc = rpc;
    imem_ack = ack;
    imem_rdata = ack ? mem_word(imem_addr) : $urandom;
    if (rd) begin
      q.delete();
      next_issue = {rpc[31:2], 2'b00};
      draining = imem_req && !ack;
    end else begin
      if (q.size() != 0 && !st) begin
        void'(q.pop_front());
        consumed++;
      end
      if (imem_req && ack) begin
        if (draining) draining = 1'b0;
        else begin
          q.push_back('{addr: imem_addr, word: mem_word(imem_addr)});
          next_issue = next_issue + INC;
        end
      end
    end
    prev_out = imem_req && !ack;
    prev_addr = imem_addr;
  endtask

  initial begin
    model_reset();

    // Free-running fetch, memory acks every request immediately.
    do_reset();
    step(0, 0, 0, 1); check("a_first_req", {31'd0, imem_req}, 32'd0);
    step(0, 0, 0, 1); check("a_issue0", imem_addr, 32'h0);
    step(0, 0, 0, 1); check("a_pc0", instr_pc, 32'h0);
    step(0, 0, 0, 1); check("a_pc4", instr_pc, 32'h4);
    step(0, 0, 0, 1); check("a_pc8", instr_pc, 32'h8);

    // Decode stalled: output plus skid fill, requests stop, nothing lost.
    do_reset();
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1); check("b_out0", instr_pc, 32'h0);
    step(1, 0, 0, 1); check("b_req_low", {31'd0, imem_req}, 32'd0);
    step(0, 0, 0, 1); check("b_hold0", instr_pc, 32'h0);
    step(0, 0, 0, 1); check("b_pc4", instr_pc, 32'h4);
    step(0, 0, 0, 1); check("b_pc8", instr_pc, 32'h8);

    // Redirect while 0x8 is in flight, redirect on ack, and pc wrap.
    do_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 32'h0000_1003, 0); check("c_inflight8", imem_addr, 32'h8);
    step(0, 0, 0, 0); check("c_flushed", {31'd0, instr_valid}, 32'd0);
    check("c_drain_pc", pc, 32'h1000);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1); check("c_drop8", {31'd0, instr_valid}, 32'd0);
    step(0, 0, 0, 1); check("c_issue1000", imem_addr, 32'h1000);
    step(0, 1, 32'h0000_2000, 1); check("c_out1000", instr_pc, 32'h1000);
    step(0, 0, 0, 1); check("d_no_valid", {31'd0, instr_valid}, 32'd0);
    step(0, 0, 0, 1); check("d_issue2000", imem_addr, 32'h2000);
    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1); check("e_issue_top", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 1); check("e_wrap", imem_addr, 32'h0);
    check("e_out_top", instr_pc, 32'hFFFF_FFFC);

    // Reset abandons an outstanding request; a late ack is ignored.
    do_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 2); check("f_ignore_ack", {31'd0, imem_req}, 32'd0);
    step(0, 0, 0, 1); check("f_first_req", imem_addr, RST_PC);
    step(0, 0, 0, 1); check("f_out_first", instr_pc, RST_PC);

    // Random traffic against the model.
    consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        st;
      logic        rd;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 9) < 4);
      rd  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | {28'd0, 4'($urandom)}) : $urandom;
      if ($urandom_range(0, 499) == 0) do_reset();
      step(st, rd, rpc, ($urandom_range(0, 9) < 6) ? 1 : 0);
    end
    check("throughput", {31'd0, consumed > 200}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
